// File: rtl/skyking_typewriter_seq.sv
// Typewriter caption sequencer for the SkyKing overlay: reveals one letter
// per FRAMES_PER_CHAR frames, holds the full line, erases, optionally loops.
module skyking_typewriter_seq #(
    parameter int N_LETTERS       = 17,
    parameter int FRAMES_PER_CHAR = 8,
    parameter int HOLD_FRAMES     = 180,
    parameter int BLINK_FRAMES    = 16,
    parameter int IDX_W           = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 start,
    input  logic                 loop_en,
    input  logic                 pause,
    output logic [N_LETTERS-1:0] letter_mask,
    output logic [IDX_W-1:0]     cursor_idx,
    output logic                 cursor_on,
    output logic                 busy,
    output logic                 done
);

    localparam int FC_MAX = (FRAMES_PER_CHAR > HOLD_FRAMES) ?
                            FRAMES_PER_CHAR : HOLD_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX + 1);
    localparam int BL_W   = $clog2(BLINK_FRAMES + 1);

    localparam logic [FC_W-1:0]  CHAR_LAST  = FC_W'(FRAMES_PER_CHAR - 1);
    localparam logic [FC_W-1:0]  HOLD_LAST  = FC_W'(HOLD_FRAMES - 1);
    localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_LETTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        TYPE,
        HOLD,
        ERASE
    } state_t;

    state_t               state, state_n;
    logic                 vsync_r, vsync_h;
    logic                 tick;
    logic [FC_W-1:0]      frame_cnt, frame_n;
    logic [BL_W-1:0]      blink_cnt, blink_n;
    logic [N_LETTERS-1:0] mask_n;
    logic [IDX_W-1:0]     idx_n;
    logic                 cursor_n;
    logic                 done_n;

    // Edges arriving while paused are dropped, never queued.
    assign tick = vsync_r & ~vsync_h & ~pause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        frame_n  = frame_cnt;
        blink_n  = blink_cnt;
        mask_n   = letter_mask;
        idx_n    = cursor_idx;
        cursor_n = cursor_on;
        done_n   = 1'b0;

        if (tick && state != TYPE) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_n  = '0;
                cursor_n = ~cursor_on;
            end else begin
                blink_n = blink_cnt + BL_W'(1);
            end
        end

        case (state)
            IDLE: begin
                mask_n = '0;
                idx_n  = '0;
                if (start) begin
                    state_n  = TYPE;
                    frame_n  = '0;
                    blink_n  = '0;
                    cursor_n = 1'b1;
                end
            end
            TYPE: begin
                cursor_n = 1'b1;
                if (tick) begin
                    if (frame_cnt == CHAR_LAST) begin
                        frame_n = '0;
                        for (int k = 0; k < N_LETTERS; k++) begin
                            if (cursor_idx == IDX_W'(k)) begin
                                mask_n[k] = 1'b1;
                            end
                        end
                        idx_n = cursor_idx + IDX_W'(1);
                        if (cursor_idx == IDX_LAST) begin
                            state_n = HOLD;
                            done_n  = 1'b1;
                        end
                    end else begin
                        frame_n = frame_cnt + FC_W'(1);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (frame_cnt == HOLD_LAST) begin
                        state_n = ERASE;
                        frame_n = '0;
                    end else begin
                        frame_n = frame_cnt + FC_W'(1);
                    end
                end
            end
            ERASE: begin
                mask_n  = '0;
                idx_n   = '0;
                frame_n = '0;
                if (loop_en) begin
                    state_n  = TYPE;
                    blink_n  = '0;
                    cursor_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_r     <= 1'b0;
            vsync_h     <= 1'b0;
            frame_cnt   <= '0;
            blink_cnt   <= '0;
            letter_mask <= '0;
            cursor_idx  <= '0;
            cursor_on   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            vsync_r     <= vsync;
            vsync_h     <= vsync_r;
            frame_cnt   <= frame_n;
            blink_cnt   <= blink_n;
            letter_mask <= mask_n;
            cursor_idx  <= idx_n;
            cursor_on   <= cursor_n;
            busy        <= (state_n != IDLE);
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_skyking_typewriter_seq.sv
// Directed bench for skyking_typewriter_seq with a 4-letter caption,
// 2 frames per letter, 3 hold frames and 2-frame blink.
module tb_skyking_typewriter_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       start;
    logic       loop_en;
    logic       pause;
    logic [3:0] letter_mask;
    logic [2:0] cursor_idx;
    logic       cursor_on;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;
    int done_seen = 0;
    int d0;

    always #5 clk = ~clk;

    skyking_typewriter_seq #(
        .N_LETTERS(4),
        .FRAMES_PER_CHAR(2),
        .HOLD_FRAMES(3),
        .BLINK_FRAMES(2),
        .IDX_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vsync(vsync),
        .start(start),
        .loop_en(loop_en),
        .pause(pause),
        .letter_mask(letter_mask),
        .cursor_idx(cursor_idx),
        .cursor_on(cursor_on),
        .busy(busy),
        .done(done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rise();
        @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rises(input int n);
        for (int i = 0; i < n; i++) rise();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        vsync   = 1'b0;
        start   = 1'b0;
        loop_en = 1'b0;
        pause   = 1'b0;

        // 1: reset with vsync toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vsync = ~vsync;
        end
        @(negedge clk);
        chk("rst_mask", 32'(letter_mask), 32'h0);
        chk("rst_idx", 32'(cursor_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cursor", 32'(cursor_on), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        vsync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 2: typewriter reveal
        pulse_start();
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_cursor", 32'(cursor_on), 32'h1);
        d0 = done_seen;
        rise();
        chk("r1_mask", 32'(letter_mask), 32'h0);
        rise();
        chk("r2_mask", 32'(letter_mask), 32'h1);
        chk("r2_idx", 32'(cursor_idx), 32'h1);
        rises(2);
        chk("r4_mask", 32'(letter_mask), 32'h3);
        rises(2);
        chk("r6_mask", 32'(letter_mask), 32'h7);
        chk("r6_done", 32'(done_seen - d0), 32'h0);
        rises(2);
        chk("r8_mask", 32'(letter_mask), 32'hf);
        chk("r8_idx", 32'(cursor_idx), 32'h4);
        chk("r8_done_once", 32'(done_seen - d0), 32'h1);
        chk("r8_done_low", 32'(done), 32'h0);

        // 3: hold, blink, erase to idle
        rise();
        chk("h1_cursor", 32'(cursor_on), 32'h1);
        rise();
        chk("h2_cursor", 32'(cursor_on), 32'h0);
        chk("h2_mask", 32'(letter_mask), 32'hf);
        rise();
        chk("idle_mask", 32'(letter_mask), 32'h0);
        chk("idle_idx", 32'(cursor_idx), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // 4: looping erase returns to TYPE
        loop_en = 1'b1;
        pulse_start();
        rises(8);
        chk("l_full", 32'(letter_mask), 32'hf);
        rises(3);
        chk("l_mask0", 32'(letter_mask), 32'h0);
        chk("l_busy", 32'(busy), 32'h1);
        rises(2);
        chk("l_mask1", 32'(letter_mask), 32'h1);

        // 5: pause freezes reveals
        rises(2);
        chk("p_pre", 32'(letter_mask), 32'h3);
        pause = 1'b1;
        rises(5);
        chk("p_hold", 32'(letter_mask), 32'h3);
        chk("p_idx", 32'(cursor_idx), 32'h2);
        pause = 1'b0;
        rises(2);
        chk("p_rel", 32'(letter_mask), 32'h7);

        // 6: start ignored while busy, then reset mid-HOLD
        pulse_start();
        chk("sb_mask", 32'(letter_mask), 32'h7);
        chk("sb_idx", 32'(cursor_idx), 32'h3);
        rises(2);
        chk("sb_full", 32'(letter_mask), 32'hf);
        rise();
        chk("mh_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_mask", 32'(letter_mask), 32'h0);
        chk("mr_idx", 32'(cursor_idx), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_cursor", 32'(cursor_on), 32'h0);
        chk("mr_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
